// File: rtl/wb_fuzz_engine.sv
// Wishbone fuzzer: fills a pattern buffer from a 32-bit Galois LFSR and
// replays it as classic single cycles in write/read/write+readback/random mode.
// Ports: clk/rst_n, start/mode/seed_load/seed_in control, wb_* master bus,
// busy/done status, sticky hang/err/mismatch flags, err_count, fail_index,
// last_rdata.
module wb_fuzz_engine #(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          BUFFER_DEPTH    = 8,
  parameter int          MAX_WAIT_CYCLES = 64,
  parameter logic [31:0] ADDR_BASE       = 32'h0,
  parameter logic [31:0] ADDR_MASK       = 32'h3C,
  parameter logic [31:0] SEED            = 32'hACE1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic                            seed_load,
  input  logic [31:0]                     seed_in,
  output logic [ADDR_WIDTH-1:0]           wb_adr_o,
  output logic [DATA_WIDTH-1:0]           wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]         wb_sel_o,
  output logic                            wb_we_o,
  output logic                            wb_stb_o,
  output logic                            wb_cyc_o,
  input  logic [DATA_WIDTH-1:0]           wb_dat_i,
  input  logic                            wb_ack_i,
  input  logic                            wb_err_i,
  output logic                            busy,
  output logic                            done,
  output logic                            hang_detected,
  output logic                            err_detected,
  output logic                            mismatch_detected,
  output logic [7:0]                      err_count,
  output logic [$clog2(BUFFER_DEPTH)-1:0] fail_index,
  output logic [DATA_WIDTH-1:0]           last_rdata
);

  localparam int IW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(MAX_WAIT_CYCLES + 1);
  localparam logic [31:0]   TAPS = 32'h80200003;
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(BUFFER_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t                  state_q;
  logic [31:0]             lfsr_q;
  logic [1:0]              mode_q;
  logic [IW-1:0]           idx_q;
  logic [CW-1:0]           wait_q;
  logic                    phase_q;
  logic                    fail_seen_q;
  logic [ADDR_WIDTH-1:0]   buf_adr_q [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0]   buf_dat_q [BUFFER_DEPTH];
  logic                    buf_we_q  [BUFFER_DEPTH];

  logic [31:0]             lfsr_d;
  logic [31:0]             adr32_d;
  logic [DATA_WIDTH-1:0]   gen_dat_d;
  logic [CW-1:0]           wait_d;
  logic                    issue_we_d;

  assign lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign adr32_d = ADDR_BASE | (lfsr_q & ADDR_MASK);
  assign wait_d  = wait_q + 1'b1;

  // Data lanes wider than 32 bits repeat the LFSR word.
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_rep
    assign gen_dat_d[g] = lfsr_q[g % 32];
  end

  // In write+readback mode phase_q selects the read half of an entry.
  always_comb begin
    issue_we_d = 1'b0;
    unique case (mode_q)
      2'b00: issue_we_d = 1'b1;
      2'b01: issue_we_d = 1'b0;
      2'b10: issue_we_d = ~phase_q;
      2'b11: issue_we_d = buf_we_q[idx_q];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      lfsr_q            <= SEED;
      mode_q            <= '0;
      idx_q             <= '0;
      wait_q            <= '0;
      phase_q           <= 1'b0;
      fail_seen_q       <= 1'b0;
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        buf_adr_q[i] <= '0;
        buf_dat_q[i] <= '0;
        buf_we_q[i]  <= 1'b0;
      end
      wb_adr_o          <= '0;
      wb_dat_o          <= '0;
      wb_sel_o          <= '0;
      wb_we_o           <= 1'b0;
      wb_stb_o          <= 1'b0;
      wb_cyc_o          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      hang_detected     <= 1'b0;
      err_detected      <= 1'b0;
      mismatch_detected <= 1'b0;
      err_count         <= '0;
      fail_index        <= '0;
      last_rdata        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (seed_load)
            lfsr_q <= (seed_in == 32'h0) ? SEED : seed_in;
          if (start) begin
            state_q           <= S_GEN;
            busy              <= 1'b1;
            mode_q            <= mode;
            idx_q             <= '0;
            phase_q           <= 1'b0;
            fail_seen_q       <= 1'b0;
            hang_detected     <= 1'b0;
            err_detected      <= 1'b0;
            mismatch_detected <= 1'b0;
            err_count         <= '0;
            fail_index        <= '0;
          end
        end
        S_GEN: begin
          buf_adr_q[idx_q] <= adr32_d[ADDR_WIDTH-1:0];
          buf_dat_q[idx_q] <= gen_dat_d;
          buf_we_q[idx_q]  <= lfsr_q[31];
          lfsr_q           <= lfsr_d;
          idx_q            <= idx_q + 1'b1;
          if (idx_q == LAST)
            state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_sel_o <= '1;
          wb_we_o  <= issue_we_d;
          wb_adr_o <= buf_adr_q[idx_q];
          wb_dat_o <= buf_dat_q[idx_q];
          wait_q   <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (wb_ack_i || wb_err_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            state_q  <= S_NEXT;
            phase_q  <= 1'b0;
            if (wb_err_i) begin
              err_detected <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 1'b1;
              if (!fail_seen_q) begin
                fail_seen_q <= 1'b1;
                fail_index  <= idx_q;
              end
            end else begin
              if (!wb_we_o)
                last_rdata <= wb_dat_i;
              if (mode_q == 2'b10 && !wb_we_o &&
                  wb_dat_i != buf_dat_q[idx_q]) begin
                mismatch_detected <= 1'b1;
                if (!fail_seen_q) begin
                  fail_seen_q <= 1'b1;
                  fail_index  <= idx_q;
                end
              end
              if (mode_q == 2'b10 && wb_we_o) begin
                phase_q <= 1'b1;
                state_q <= S_ISSUE;
              end
            end
          end else if (wait_d == WMAX) begin
            // Timeout aborts the rest of the batch.
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_sel_o      <= '0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            hang_detected <= 1'b1;
            if (!fail_seen_q) begin
              fail_seen_q <= 1'b1;
              fail_index  <= idx_q;
            end
            state_q <= S_DONE;
            done    <= 1'b1;
          end else begin
            wait_q <= wait_d;
          end
        end
        S_NEXT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_fuzz_engine.sv
// Directed bench for wb_fuzz_engine with a behavioural Wishbone slave
// (memory, corrupt read, hang, ack+err) and a reference LFSR model.
module tb_wb_fuzz_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic        seed_load;
  logic [31:0] seed_in;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        busy;
  logic        done;
  logic        hang_detected;
  logic        err_detected;
  logic        mismatch_detected;
  logic [7:0]  err_count;
  logic [2:0]  fail_index;
  logic [31:0] last_rdata;

  wb_fuzz_engine #(
    .MAX_WAIT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .seed_load(seed_load), .seed_in(seed_in),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(rdat), .wb_ack_i(ack), .wb_err_i(err),
    .busy(busy), .done(done), .hang_detected(hang_detected),
    .err_detected(err_detected), .mismatch_detected(mismatch_detected),
    .err_count(err_count), .fail_index(fail_index),
    .last_rdata(last_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // slave configuration and log
  int          hang_tx = -1;
  int          bad_tx  = -1;
  logic        err_all = 1'b0;
  int          ntx = 0;
  int          stb_cycles = 0;
  logic        infl = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];
  logic        log_we  [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      err  <= 1'b0;
      infl <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (wb_stb_o) stb_cycles <= stb_cycles + 1;
      if (!wb_stb_o) begin
        infl <= 1'b0;
      end else if (!infl) begin
        infl <= 1'b1;
        log_adr.push_back(wb_adr_o);
        log_dat.push_back(wb_dat_o);
        log_we.push_back(wb_we_o);
        if (ntx != hang_tx) begin
          ack <= 1'b1;
          err <= err_all;
          if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
          rdat <= (mem.exists(wb_adr_o) ? mem[wb_adr_o]
                   : (32'hC0DE0000 | ntx))
                  ^ ((ntx == bad_tx) ? 32'h1 : 32'h0);
        end
        ntx <= ntx + 1;
      end
    end
  end

  // reference model
  logic [31:0] m_lfsr;
  logic [31:0] exp_l [8];
  int          lat;
  int          dones;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      exp_l[i] = m_lfsr;
      m_lfsr   = lfsr_next(m_lfsr);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    ntx = 0;
    stb_cycles = 0;
    mem.delete();
    log_adr.delete();
    log_dat.delete();
    log_we.delete();
  endtask

  task automatic run_batch(input logic [1:0] md);
    lat = -1;
    dones = 0;
    clear_slave();
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      #1;
      if (wb_stb_o && lat < 0) lat = c;
      if (done) dones++;
      if (dones > 0 && !busy) break;
    end
    chk("batch_finished", dones > 0, 1);
  endtask

  task automatic load_seed(input logic [31:0] v);
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = v;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    seed_load = 1'b0;
    seed_in = 32'h0;
    rdat = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_errcnt", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // mode 00, plain acking slave
    m_lfsr = 32'hACE1;
    fill();
    run_batch(2'b00);
    chk("m0_latency", lat, 9);
    chk("m0_dones", dones, 1);
    chk("m0_ntx", ntx, 8);
    chk("m0_adr0", log_adr[0], 32'h20);
    chk("m0_dat1", log_dat[1], 32'h80205673);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("m0_adr%0d", i), log_adr[i], exp_l[i] & 32'h3C);
      chk($sformatf("m0_dat%0d", i), log_dat[i], exp_l[i]);
      chk($sformatf("m0_we%0d", i), log_we[i], 1);
    end
    chk("m0_flags", {hang_detected, err_detected, mismatch_detected}, 0);
    chk("m0_busy_after", busy, 0);

    // mode 10, memory slave
    fill();
    run_batch(2'b10);
    chk("m2_ntx", ntx, 16);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("m2_wadr%0d", i), log_adr[2*i], exp_l[i] & 32'h3C);
      chk($sformatf("m2_radr%0d", i), log_adr[2*i+1], exp_l[i] & 32'h3C);
      chk($sformatf("m2_dir%0d", i), {log_we[2*i], log_we[2*i+1]}, 2'b10);
    end
    chk("m2_mismatch", mismatch_detected, 0);
    chk("m2_err", err_detected, 0);

    // mode 10, corrupt read of entry 3
    fill();
    bad_tx = 7;
    run_batch(2'b10);
    bad_tx = -1;
    chk("m2c_ntx", ntx, 16);
    chk("m2c_mismatch", mismatch_detected, 1);
    chk("m2c_fail_index", fail_index, 3);
    chk("m2c_hang", hang_detected, 0);

    // hang on entry 2
    fill();
    hang_tx = 2;
    run_batch(2'b00);
    chk("hang_flag", hang_detected, 1);
    chk("hang_fail_index", fail_index, 2);
    chk("hang_dones", dones, 1);
    chk("hang_stb_cycles", stb_cycles, 20);
    repeat (30) @(posedge clk);
    #1;
    chk("hang_no_more_tx", ntx, 3);
    chk("hang_cyc_idle", wb_cyc_o, 0);
    hang_tx = -1;

    // ack and err together on every entry
    fill();
    err_all = 1'b1;
    run_batch(2'b00);
    err_all = 1'b0;
    chk("err_count", err_count, 8);
    chk("err_flag", err_detected, 1);
    chk("err_fail_index", fail_index, 0);
    chk("err_ntx", ntx, 8);
    chk("err_hang", hang_detected, 0);

    // mode 11, direction from entry bit 31
    fill();
    run_batch(2'b11);
    for (int i = 0; i < 8; i++)
      chk($sformatf("m3_we%0d", i), log_we[i], exp_l[i][31]);

    // zero seed reloads the default
    load_seed(32'h0);
    m_lfsr = 32'hACE1;
    fill();
    run_batch(2'b00);
    chk("seed0_adr0", log_adr[0], 32'h20);
    for (int i = 0; i < 8; i++)
      chk($sformatf("seed0_adr%0d", i), log_adr[i], exp_l[i] & 32'h3C);

    // explicit seed, read mode
    load_seed(32'h12345678);
    m_lfsr = 32'h12345678;
    fill();
    run_batch(2'b01);
    chk("seed1_adr0", log_adr[0], 32'h38);
    chk("seed1_adr7", log_adr[7], exp_l[7] & 32'h3C);
    chk("seed1_we0", log_we[0], 0);
    chk("seed1_we7", log_we[7], 0);
    chk("seed1_last_rdata", last_rdata, 32'hC0DE0007);

    // async reset during WAIT
    clear_slave();
    err_all = 1'b1;
    hang_tx = 3;
    @(negedge clk);
    mode  = 2'b00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 300 && ntx < 4; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_reached", ntx, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_errcnt_pre", err_count, 3);
    chk("rst_mid_stb_pre", wb_stb_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", wb_cyc_o, 0);
    chk("rst_mid_stb", wb_stb_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    err_all = 1'b0;
    hang_tx = -1;
    @(posedge clk);
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_errcnt", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
